// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding-select and load-use stall generator driven by a shift register of in-flight destinations.
// Stage 0 is the instruction in EX; stages 1..FWD_DEPTH are the post-EX stages that can forward.
module fwd_hazard_scoreboard #(
   parameter int NUM_SRC   = 2,
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 2,
   parameter int LOAD_LAT  = 2
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    id_valid_i,
   input  logic [NUM_SRC*REG_AW-1:0]               id_rs_i,
   input  logic [NUM_SRC-1:0]                      id_rs_use_i,
   input  logic [REG_AW-1:0]                       id_rd_i,
   input  logic                                    id_rw_i,
   input  logic                                    id_load_i,
   input  logic                                    flush_i,
   input  logic                                    freeze_i,
   output logic [NUM_SRC*$clog2(FWD_DEPTH+1)-1:0]  fwd_sel_o,
   output logic                                    stall_o,
   output logic [31:0]                             stall_cnt_o
);

   localparam int SEL_W = $clog2(FWD_DEPTH + 1);

   logic [FWD_DEPTH:0]  st_valid;
   logic [FWD_DEPTH:0]  st_rw;
   logic [FWD_DEPTH:0]  st_load;
   logic [REG_AW-1:0]   st_rd [FWD_DEPTH+1];
   logic [REG_AW-1:0]   ex_rs [NUM_SRC];
   logic [NUM_SRC-1:0]  ex_use;
   logic [NUM_SRC-1:0]  src_hz;
   logic                issue;

   assign issue = id_valid_i & ~stall_o & ~flush_i;

   // A bubble only clears valid/use; the stale rd/rw/load bits behind it are never looked at.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_valid <= '0;
         st_rw    <= '0;
         st_load  <= '0;
         ex_use   <= '0;
         for (int k = 0; k <= FWD_DEPTH; k++) st_rd[k] <= '0;
         for (int s = 0; s < NUM_SRC; s++) ex_rs[s] <= '0;
      end else if (!freeze_i) begin
         for (int k = 0; k < FWD_DEPTH; k++) begin
            st_valid[k+1] <= st_valid[k];
            st_rw[k+1]    <= st_rw[k];
            st_load[k+1]  <= st_load[k];
            st_rd[k+1]    <= st_rd[k];
         end
         if (issue) begin
            st_valid[0] <= 1'b1;
            st_rw[0]    <= id_rw_i;
            st_load[0]  <= id_load_i;
            st_rd[0]    <= id_rd_i;
            ex_use      <= id_rs_use_i;
            for (int s = 0; s < NUM_SRC; s++) ex_rs[s] <= id_rs_i[s*REG_AW +: REG_AW];
         end else begin
            st_valid[0] <= 1'b0;
            ex_use      <= '0;
         end
      end
   end

   // Scanning oldest-to-youngest lets the nearest producer overwrite older ones.
   always_comb begin
      fwd_sel_o = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (st_valid[k] && st_rw[k] && (st_rd[k] != '0) && (st_rd[k] == ex_rs[s]) && ex_use[s])
               fwd_sel_o[s*SEL_W +: SEL_W] = SEL_W'(FWD_DEPTH + 1 - k);
         end
      end
   end

   // Only the youngest writer decides, so a younger ALU result masks an older load.
   always_comb begin
      src_hz = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
            if (st_valid[j] && st_rw[j] && (st_rd[j] != '0) &&
                (st_rd[j] == id_rs_i[s*REG_AW +: REG_AW]) && id_rs_use_i[s])
               src_hz[s] = st_load[j] && (j <= LOAD_LAT - 2);
         end
      end
   end

   assign stall_o = (|src_hz) & id_valid_i & ~flush_i & ~rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt_o <= '0;
      else if (stall_o && !freeze_i && (stall_cnt_o != 32'hFFFF_FFFF))
         stall_cnt_o <= stall_cnt_o + 32'd1;
   end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard: a default instance and a 3-source/3-deep/LOAD_LAT=3 instance.
// Stimulus pushes hand-computed expectations into a queue; a negedge monitor pops and compares them.
module tb_fwd_hazard_scoreboard;

   logic clk;

   logic        a_rst, a_valid, a_rw, a_load, a_flush, a_freeze;
   logic [9:0]  a_rs;
   logic [1:0]  a_use;
   logic [4:0]  a_rd;
   logic [3:0]  a_sel;
   logic        a_stall;
   logic [31:0] a_cnt;

   logic        b_rst, b_valid, b_rw, b_load, b_flush, b_freeze;
   logic [14:0] b_rs;
   logic [2:0]  b_use;
   logic [4:0]  b_rd;
   logic [5:0]  b_sel;
   logic        b_stall;
   logic [31:0] b_cnt;

   typedef struct {
      int cyc;
      int dut;
      int tag;
      int sel;
      int stall;
      int cnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_rec;
   int   cyc;
   int   tag_ctr;
   int   total;
   int   passed;

   fwd_hazard_scoreboard #(.NUM_SRC(2), .REG_AW(5), .FWD_DEPTH(2), .LOAD_LAT(2)) dut_a (
      .clk_i(clk), .rst_i(a_rst), .id_valid_i(a_valid), .id_rs_i(a_rs), .id_rs_use_i(a_use),
      .id_rd_i(a_rd), .id_rw_i(a_rw), .id_load_i(a_load), .flush_i(a_flush), .freeze_i(a_freeze),
      .fwd_sel_o(a_sel), .stall_o(a_stall), .stall_cnt_o(a_cnt)
   );

   fwd_hazard_scoreboard #(.NUM_SRC(3), .REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(3)) dut_b (
      .clk_i(clk), .rst_i(b_rst), .id_valid_i(b_valid), .id_rs_i(b_rs), .id_rs_use_i(b_use),
      .id_rd_i(b_rd), .id_rw_i(b_rw), .id_load_i(b_load), .flush_i(b_flush), .freeze_i(b_freeze),
      .fwd_sel_o(b_sel), .stall_o(b_stall), .stall_cnt_o(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Drives one cycle of ID-side inputs on the selected instance, just after the clock edge.
   task automatic applyStimulus(input int dut, input logic rst, input logic frz, input logic fl,
                                input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                                input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] su);
      @(posedge clk);
      #1;
      if (dut == 0) begin
         a_rst = rst; a_freeze = frz; a_flush = fl; a_valid = v;
         a_rd = rd; a_rw = rw; a_load = ld; a_rs = {rs1, rs0}; a_use = su[1:0];
      end else begin
         b_rst = rst; b_freeze = frz; b_flush = fl; b_valid = v;
         b_rd = rd; b_rw = rw; b_load = ld; b_rs = {rs2, rs1, rs0}; b_use = su;
      end
   endtask

   // Any field given as -1 is not compared for that cycle.
   task automatic expectOutput(input int dut, input int sel, input int stall, input int cnt);
      exp_t e;
      e.cyc = cyc; e.dut = dut; e.tag = tag_ctr;
      e.sel = sel; e.stall = stall; e.cnt = cnt;
      tag_ctr++;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      int          act_sel;
      logic        act_stall;
      logic [31:0] act_cnt;
      act_sel   = (e.dut == 0) ? int'(a_sel) : int'(b_sel);
      act_stall = (e.dut == 0) ? a_stall : b_stall;
      act_cnt   = (e.dut == 0) ? a_cnt : b_cnt;
      if (e.sel >= 0) begin
         total++;
         if (act_sel == e.sel) passed++;
         else $display("[TB] FAIL sel dut%0d #%0d: got %0h expected %0h", e.dut, e.tag, act_sel, e.sel);
      end
      if (e.stall >= 0) begin
         total++;
         if (act_stall == e.stall[0]) passed++;
         else $display("[TB] FAIL stall dut%0d #%0d: got %0b expected %0b", e.dut, e.tag, act_stall, e.stall[0]);
      end
      if (e.cnt >= 0) begin
         total++;
         if (act_cnt == 32'(e.cnt)) passed++;
         else $display("[TB] FAIL cnt dut%0d #%0d: got %0d expected %0d", e.dut, e.tag, act_cnt, e.cnt);
      end
   endtask

   // Monitor: compares every expectation queued for the current cycle at the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_rec = sb.pop_front();
         if (mon_rec.cyc < cyc) begin
            total++;
            $display("[TB] FAIL stale dut%0d #%0d: got no sample expected one in cycle %0d", mon_rec.dut, mon_rec.tag, mon_rec.cyc);
         end else begin
            checkOutput(mon_rec);
         end
      end
   end

   initial begin
      total = 0; passed = 0; tag_ctr = 0;
      a_rst = 1; a_freeze = 0; a_flush = 0; a_valid = 0; a_rd = 0; a_rw = 0; a_load = 0; a_rs = 0; a_use = 0;
      b_rst = 1; b_freeze = 0; b_flush = 0; b_valid = 0; b_rd = 0; b_rw = 0; b_load = 0; b_rs = 0; b_use = 0;

      // Instance A: reset state
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(0, 0, 0, 0);
      // add x1 ; add x2,x1,x0 -> EX/MEM forward on src0
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3'b000); expectOutput(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 3'b011); expectOutput(0, 0, 0, -1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(0, 2, 0, -1);
      // add x1 ; nop ; sub x3,x1,x1 -> MEM/WB on both sources
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3'b000); expectOutput(0, 0, -1, -1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
      applyStimulus(0, 0, 0, 0, 1, 3, 1, 0, 1, 1, 0, 3'b011); expectOutput(0, -1, 0, -1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(0, 5, 0, -1);
      // add x5 ; addi x5 ; or x6,x5 -> youngest producer wins
      applyStimulus(0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(0, 0, 0, 0, 1, 6, 1, 0, 5, 0, 0, 3'b001);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(0, 2, -1, -1);
      // lw x3 ; add x4,x3 -> one stall cycle, then MEM/WB forward
      applyStimulus(0, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 3'b000); expectOutput(0, -1, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 4, 1, 0, 3, 0, 0, 3'b001); expectOutput(0, -1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 4, 1, 0, 3, 0, 0, 3'b001); expectOutput(0, -1, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(0, 1, 0, 1);
      // lw x0 ; user of x0 -> no stall, no forward
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 3'b000);
      applyStimulus(0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 3'b001); expectOutput(0, -1, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(0, 0, -1, -1);
      // lw x3 ; dependent flushed -> no stall, bubble enters EX
      applyStimulus(0, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 3'b000);
      applyStimulus(0, 0, 0, 1, 1, 4, 1, 0, 3, 0, 0, 3'b001); expectOutput(0, -1, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 3'b000); expectOutput(0, 0, 0, 1);
      // lw x3 (reads x9) ; add x4,x3 stalled and frozen for three cycles
      applyStimulus(0, 0, 0, 0, 1, 3, 1, 1, 9, 0, 0, 3'b001); expectOutput(0, -1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 0, 1, 4, 1, 0, 3, 0, 0, 3'b001); expectOutput(0, 2, 1, 1);
      end
      applyStimulus(0, 0, 0, 0, 1, 4, 1, 0, 3, 0, 0, 3'b001); expectOutput(0, 2, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 4, 1, 0, 3, 0, 0, 3'b001); expectOutput(0, 0, 0, 2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(0, 1, 0, 2);
      // Non-writing instruction to x5 never forwards
      applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 3'b000);
      applyStimulus(0, 0, 0, 0, 1, 4, 1, 0, 5, 0, 0, 3'b001); expectOutput(0, -1, 0, -1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(0, 0, -1, -1);

      // Instance B: reset state
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(1, 0, 0, 0);
      // lw x7 ; consumer on src2 -> two stall cycles, then sel 1 from stage 3
      applyStimulus(1, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 3'b000); expectOutput(1, -1, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 8, 1, 0, 0, 0, 7, 3'b100); expectOutput(1, -1, 1, 0);
      applyStimulus(1, 0, 0, 0, 1, 8, 1, 0, 0, 0, 7, 3'b100); expectOutput(1, -1, 1, 1);
      applyStimulus(1, 0, 0, 0, 1, 8, 1, 0, 0, 0, 7, 3'b100); expectOutput(1, -1, 0, 2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(1, 16, 0, 2);
      // lw x7 ; add x7 ; consumer -> younger ALU write masks the load
      applyStimulus(1, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 0, 1, 8, 1, 0, 7, 0, 0, 3'b001); expectOutput(1, -1, 0, 2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000); expectOutput(1, 3, 0, -1);
      // lw x7 ; consumer on src1, reset asserted in the second stall cycle
      applyStimulus(1, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 0, 1, 8, 1, 0, 0, 7, 0, 3'b010); expectOutput(1, -1, 1, 2);
      applyStimulus(1, 1, 0, 0, 1, 8, 1, 0, 0, 7, 0, 3'b010); expectOutput(1, -1, 0, 3);
      applyStimulus(1, 0, 0, 0, 1, 8, 1, 0, 0, 7, 0, 3'b010); expectOutput(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      while (sb.size() > 0) begin
         mon_rec = sb.pop_front();
         total++;
         $display("[TB] FAIL timeout dut%0d #%0d: got no sample expected one in cycle %0d", mon_rec.dut, mon_rec.tag, mon_rec.cyc);
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
